tt_load_drain_ctrl: RTL

Drain sequencer between the OVI load scoreboard and the load queue (LQ). When the scoreboard signals that a load has received sync-end and is ready to drain, this block latches the starting LQ id and entry count. It then walks the LQ entries in order, with wrap-around, and issues one writeback per entry to the VRF write port. Each accepted writeback pulses the per-entry LQ commit that frees the entry and decrements the scoreboard reference count.

---
 rtl/tt_vpu_ovi_pkg.sv | 23 ++
 rtl/tt_load_drain_ctrl.sv | 98 +++++++++
 2 files changed

// File: rtl/tt_vpu_ovi_pkg.sv
// ============================================================================
// Module      : tt_vpu_ovi_pkg
// Description : Types and constants shared by the OVI load scoreboard and
//               the load-queue drain sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package tt_vpu_ovi_pkg;

    localparam int c_LQ_DEPTH    = 8;
    localparam int c_LQID_W      = 3;
    localparam int c_REF_CNT_W   = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } drain_state_e;

endpackage : tt_vpu_ovi_pkg

`default_nettype wire

// File: rtl/tt_load_drain_ctrl.sv
// ============================================================================
// Module      : tt_load_drain_ctrl
// Description : Walks LQ entries in order (with wrap) after a scoreboard
//               drain request, issuing one VRF writeback + commit per entry.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tt_load_drain_ctrl
    import tt_vpu_ovi_pkg::*;
#(
    parameter int LQ_DEPTH = c_LQ_DEPTH,
    parameter int LQID_W   = c_LQID_W
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_drain_load_buffer,
    input  logic [c_REF_CNT_W-1:0] i_drain_ref_count,
    input  logic [LQID_W-1:0]      i_drain_lqid_start,
    output logic                   o_draining_load_buffer,
    input  logic [LQ_DEPTH-1:0]    i_lq_data_valid,
    output logic                   o_wb_valid,
    output logic [LQID_W-1:0]      o_wb_lqid,
    input  logic                   i_wb_ready,
    output logic                   o_lq_commit,
    output logic [LQID_W-1:0]      o_dest_lqid,
    output logic                   o_busy
);

    drain_state_e             state_q, state_d;
    logic [LQID_W-1:0]        cur_lqid_q, cur_lqid_d;
    logic [c_REF_CNT_W-1:0]   remaining_q, remaining_d;
    logic                     wb_valid;
    logic                     handshake;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cur_lqid_q  <= '0;
            remaining_q <= '0;
        end else begin
            state_q     <= state_d;
            cur_lqid_q  <= cur_lqid_d;
            remaining_q <= remaining_d;
        end
    end

    always_comb begin
        state_d                = state_q;
        cur_lqid_d             = cur_lqid_q;
        remaining_d            = remaining_q;
        wb_valid               = 1'b0;
        handshake              = 1'b0;
        o_draining_load_buffer = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                // Combinational draining on the accept cycle keeps the
                // scoreboard from seeing a spurious "done".
                o_draining_load_buffer = i_drain_load_buffer;
                if (i_drain_load_buffer) begin
                    cur_lqid_d  = i_drain_lqid_start;
                    remaining_d = i_drain_ref_count;
                    state_d     = (i_drain_ref_count == '0) ? ST_DONE : ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                o_draining_load_buffer = 1'b1;
                wb_valid  = i_lq_data_valid[cur_lqid_q] && (remaining_q != '0);
                handshake = wb_valid && i_wb_ready;
                if (handshake) begin
                    cur_lqid_d  = cur_lqid_q + LQID_W'(1);
                    remaining_d = remaining_q - c_REF_CNT_W'(1);
                    if (remaining_q == c_REF_CNT_W'(1)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Suppress writeback/commit while reset is asserted so a mid-drain reset
    // never frees an entry the LQ is simultaneously clearing.
    assign o_wb_valid  = wb_valid && !reset;
    assign o_lq_commit = handshake && !reset;
    assign o_wb_lqid   = cur_lqid_q;
    assign o_dest_lqid = cur_lqid_q;
    assign o_busy      = (state_q != ST_IDLE);

endmodule : tt_load_drain_ctrl

`default_nettype wire
